// File: rtl/fb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_port_arbiter_if
// Description : Bundles the scan-out read port, the camera write handshake,
//               the frame-buffer RAM port and the status flags of the
//               frame-buffer port arbiter.
//               slave  : arbiter view (requests in, RAM controls out)
//               master : requester / RAM / host view (mirror of slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    // scan-out read port
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    // camera write handshake
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    // frame-buffer RAM port
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    // status
    logic              starve;
    logic              addr_err;
    logic              flag_clr;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata, flag_clr,
        output rd_valid, rd_data, wr_ready, ram_en, ram_we, ram_addr, ram_wdata,
               starve, addr_err
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata, flag_clr,
        input  rd_valid, rd_data, wr_ready, ram_en, ram_we, ram_addr, ram_wdata,
               starve, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_port_arbiter
// Description : Shares a single-port frame-buffer RAM between the VGA
//               scan-out reader (strict priority) and the camera pixel
//               writer (one-entry holding register, valid/ready).
// Ports       : clk_in   - system clock, rising edge
//               rst_n    - asynchronous active-low reset
//               bus      - fb_port_arbiter_if.slave (read port, write
//                          handshake, RAM port, starve/addr_err/flag_clr)
// Revision    : 1.0 - initial release
// ============================================================================
module fb_port_arbiter #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 8,
    parameter int FB_DEPTH = 76800,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    fb_port_arbiter_if.slave bus
);

    // One extra bit so FB_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] C_DEPTH    = (ADDR_W+1)'(FB_DEPTH);
    localparam logic [7:0]      C_MAX_WAIT = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

    gnt_e              w_gnt;
    logic              w_drain_now;
    logic              w_wr_ready;
    logic              w_accept;
    logic              w_in_range;

    logic              hold_full_q, hold_full_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [7:0]        wait_q,      wait_d;
    logic              starve_q,    starve_d;
    logic              addr_err_q,  addr_err_d;
    logic              ram_en_q,    ram_en_d;
    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [RD_LAT+1:0] rd_pipe_q,   rd_pipe_d;
    logic [DATA_W-1:0] rd_data_q,   rd_data_d;

    // Reads always win; a held pixel only drains on a cycle with no read.
    always_comb begin
        w_gnt = GNT_NONE;
        if (bus.rd_req) begin
            w_gnt = GNT_RD;
        end else if (hold_full_q) begin
            w_gnt = GNT_WR;
        end
    end

    assign w_drain_now = (w_gnt == GNT_WR);
    // Gated by rst_n so the camera sees not-ready while reset is asserted.
    assign w_wr_ready  = rst_n && (!hold_full_q || w_drain_now);
    assign w_accept    = bus.wr_valid && w_wr_ready;
    assign w_in_range  = ({1'b0, bus.wr_addr} < C_DEPTH);

    always_comb begin
        hold_full_d = hold_full_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        wait_d      = wait_q;
        starve_d    = starve_q;
        addr_err_d  = addr_err_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        // Out-of-range pixels are swallowed: handshake completes, nothing loads.
        if (w_accept && w_in_range) begin
            hold_full_d = 1'b1;
            hold_addr_d = bus.wr_addr;
            hold_data_d = bus.wr_data;
        end else if (w_drain_now) begin
            hold_full_d = 1'b0;
        end

        if (bus.flag_clr) begin
            starve_d   = 1'b0;
            addr_err_d = 1'b0;
        end

        if (w_drain_now) begin
            wait_d = 8'd0;
        end else if (hold_full_q && (wait_q != 8'hFF)) begin
            wait_d = wait_q + 8'd1;
            if (wait_d == C_MAX_WAIT) begin
                starve_d = 1'b1;
            end
        end

        if (w_accept && !w_in_range) begin
            addr_err_d = 1'b1;
        end

        case (w_gnt)
            GNT_RD: begin
                ram_en_d   = 1'b1;
                ram_addr_d = bus.rd_addr;
            end
            GNT_WR: begin
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = hold_addr_q;
                ram_wdata_d = hold_data_q;
            end
            default: ;
        endcase

        // Tap RD_LAT marks the cycle ram_rdata carries the requested pixel.
        rd_pipe_d = {rd_pipe_q[RD_LAT:0], bus.rd_req};
        rd_data_d = rd_pipe_q[RD_LAT] ? bus.ram_rdata : rd_data_q;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hold_full_q <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            wait_q      <= 8'd0;
            starve_q    <= 1'b0;
            addr_err_q  <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_pipe_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            addr_err_q  <= addr_err_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rd_pipe_q   <= rd_pipe_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.rd_valid  = rd_pipe_q[RD_LAT+1];
    assign bus.rd_data   = rd_data_q;
    assign bus.starve    = starve_q;
    assign bus.addr_err  = addr_err_q;

endmodule
`default_nettype wire
